// File: rtl/my_tx_uart_fifo_if.sv
// ---------------------------------------------------------------------------
// my_tx_uart_fifo_if
//
// Write-side handshake bundle for the buffered UART transmitter.
//
// Signals:
//   in_valid  master -> slave  write request
//   in_data   master -> slave  word to transmit (DATA_BITS wide)
//   in_ready  slave  -> master transmitter FIFO can accept a word
//
// A word transfers on every rising clock edge where in_valid && in_ready.
// ---------------------------------------------------------------------------
interface my_tx_uart_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/my_tx_uart_fifo.sv
// ---------------------------------------------------------------------------
// my_tx_uart_fifo
//
// Buffered UART transmitter. Words arrive over a valid/ready handshake into
// a FIFO_DEPTH-entry FIFO and are serialised LSB-first as
//   start(0) | DATA_BITS data | optional parity | STOP_BITS stop(1)
// with every bit lasting CYCLES_PER_BIT = SYSTEM_CLK_HZ / BAUDRATE cycles.
// Frames are sent back-to-back while the FIFO holds data.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   bus         write handshake (in_valid, in_data, in_ready), slave side
//   tx_out      serial line, idles high
//   busy        high whenever a frame is in progress
//   fifo_count  number of words currently held in the FIFO
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | line high; pops the FIFO as soon as it holds a word
//   S_START  | start bit (line low) for one bit time
//   S_DATA   | data bits, shift[0] on the line, shifting right per bit
//   S_PARITY | parity bit for one bit time (only when PARITY != 0)
//   S_STOP   | line high for STOP_BITS bit times; may pop straight to START
// ---------------------------------------------------------------------------
module my_tx_uart_fifo #(
    parameter int SYSTEM_CLK_HZ = 25000000,
    parameter int BAUDRATE      = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    my_tx_uart_fifo_if.slave                  bus,
    output logic                              tx_out,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int CYCLES_PER_BIT = SYSTEM_CLK_HZ / BAUDRATE;
    localparam int BW = $clog2(CYCLES_PER_BIT + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    // One counter serves both the data-bit count and the stop-bit count;
    // DATA_BITS is always the larger of the two.
    localparam int NW = $clog2(DATA_BITS + 1);
    localparam logic ODD = (PARITY == 2);

    // -----------------------------------------------------------------------
    // Parameter legality
    // -----------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("my_tx_uart_fifo: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("my_tx_uart_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("my_tx_uart_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("my_tx_uart_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (BAUDRATE <= 0 || CYCLES_PER_BIT < 2) begin : g_bad_baud
        $error("my_tx_uart_fifo: SYSTEM_CLK_HZ / BAUDRATE must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] head;

    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic [BW-1:0]        baud_cnt;
    logic [NW-1:0]        bit_left;

    logic                 push;
    logic                 pop;
    logic                 bit_done;
    logic                 last_stop;

    // -----------------------------------------------------------------------
    // Handshake and pop decision
    // -----------------------------------------------------------------------
    assign head          = mem[rd_ptr];
    assign bus.in_ready  = (count != CW'(FIFO_DEPTH));
    assign push          = bus.in_valid && bus.in_ready;
    assign fifo_count    = count;

    // Baud down-counter terminal count: last cycle of the current bit.
    assign bit_done  = (baud_cnt == BW'(1));
    assign last_stop = (state == S_STOP) && bit_done && (bit_left == NW'(1));

    // Popping from the last stop cycle (not only from IDLE) is what makes
    // consecutive frames run with zero idle cycles between them.
    assign pop = (count != '0) && ((state == S_IDLE) || last_stop);

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset: a word is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // -----------------------------------------------------------------------
    // Frame sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            shift    <= '0;
            par_bit  <= 1'b0;
            baud_cnt <= BW'(CYCLES_PER_BIT);
            bit_left <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= BW'(CYCLES_PER_BIT);
                    if (pop) begin
                        state   <= S_START;
                        shift   <= head;
                        par_bit <= (^head) ^ ODD;
                        tx_out  <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        tx_out  <= 1'b1;
                        busy    <= 1'b0;
                    end
                end

                S_START: begin
                    if (bit_done) begin
                        baud_cnt <= BW'(CYCLES_PER_BIT);
                        state    <= S_DATA;
                        tx_out   <= shift[0];
                        bit_left <= NW'(DATA_BITS);
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end

                S_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= BW'(CYCLES_PER_BIT);
                        if (bit_left == NW'(1)) begin
                            if (PARITY != 0) begin
                                state  <= S_PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                tx_out   <= 1'b1;
                                bit_left <= NW'(STOP_BITS);
                            end
                        end else begin
                            // shift[1] is the bit that becomes shift[0] now.
                            shift    <= shift >> 1;
                            tx_out   <= shift[1];
                            bit_left <= bit_left - NW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_done) begin
                        baud_cnt <= BW'(CYCLES_PER_BIT);
                        state    <= S_STOP;
                        tx_out   <= 1'b1;
                        bit_left <= NW'(STOP_BITS);
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end

                S_STOP: begin
                    if (bit_done) begin
                        baud_cnt <= BW'(CYCLES_PER_BIT);
                        if (bit_left == NW'(1)) begin
                            if (pop) begin
                                state   <= S_START;
                                shift   <= head;
                                par_bit <= (^head) ^ ODD;
                                tx_out  <= 1'b0;
                                busy    <= 1'b1;
                            end else begin
                                state   <= S_IDLE;
                                tx_out  <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end else begin
                            bit_left <= bit_left - NW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    tx_out   <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= BW'(CYCLES_PER_BIT);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_tx_uart_fifo.sv
// ---------------------------------------------------------------------------
// tb_my_tx_uart_fifo
//
// Five transmitter instances with different framing share one clock and
// reset (16 cycles per bit in all of them):
//   0: 8N1, depth 16     1: 8E1, depth 16     2: 8O1, depth 16
//   3: 9N2, depth 16     4: 8N1, depth 4
// The reference model holds each FIFO as a queue of words and the line as a
// queue of per-cycle levels: a popped word is expanded into its whole
// frame, one entry per clock cycle.
// ---------------------------------------------------------------------------
module tb_my_tx_uart_fifo;

    localparam int NI  = 5;
    localparam int CPB = 16;

    function automatic int db_of(int g); return (g == 3) ? 9 : 8; endfunction
    function automatic int pa_of(int g); return (g == 1) ? 1 : ((g == 2) ? 2 : 0); endfunction
    function automatic int sb_of(int g); return (g == 3) ? 2 : 1; endfunction
    function automatic int fd_of(int g); return (g == 4) ? 4 : 16; endfunction
    function automatic int frame_len(int g);
        return (1 + db_of(g) + ((pa_of(g) != 0) ? 1 : 0) + sb_of(g)) * CPB;
    endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NI-1:0]      vld_v;
    logic [8:0]         dat_v [NI];
    logic [NI-1:0]      tx_v;
    logic [NI-1:0]      busy_v;
    logic [NI-1:0]      rdy_v;
    logic [NI-1:0][4:0] cnt_v;

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int DB = db_of(g);
        localparam int CW = $clog2(fd_of(g) + 1);
        my_tx_uart_fifo_if #(.DATA_BITS(DB)) bus ();
        logic          tx;
        logic          bz;
        logic [CW-1:0] fc;
        assign bus.in_valid = vld_v[g];
        assign bus.in_data  = dat_v[g][DB-1:0];
        assign rdy_v[g]     = bus.in_ready;
        assign tx_v[g]      = tx;
        assign busy_v[g]    = bz;
        assign cnt_v[g]     = 5'(fc);
        my_tx_uart_fifo #(
            .SYSTEM_CLK_HZ (1600),
            .BAUDRATE      (100),
            .DATA_BITS     (DB),
            .PARITY        (pa_of(g)),
            .STOP_BITS     (sb_of(g)),
            .FIFO_DEPTH    (fd_of(g))
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .bus        (bus),
            .tx_out     (tx),
            .busy       (bz),
            .fifo_count (fc)
        );
    end

    // ---------------------------------------------------------------- model
    int unsigned mq [NI][$];
    bit          ml [NI][$];

    task automatic add_frame(int g, int unsigned w);
        bit p;
        p = 1'b0;
        repeat (CPB) ml[g].push_back(1'b0);
        for (int i = 0; i < db_of(g); i++) begin
            p = p ^ w[i];
            repeat (CPB) ml[g].push_back(w[i]);
        end
        if (pa_of(g) != 0) repeat (CPB) ml[g].push_back(p ^ (pa_of(g) == 2));
        repeat (CPB * sb_of(g)) ml[g].push_back(1'b1);
    endtask

    always @(posedge clk or posedge reset) begin
        bit          take;
        int unsigned w;
        if (reset) begin
            for (int g = 0; g < NI; g++) begin
                mq[g].delete();
                ml[g].delete();
            end
        end else begin
            for (int g = 0; g < NI; g++) begin
                take = vld_v[g] && (mq[g].size() != fd_of(g));
                w    = 32'(dat_v[g]) & ((32'd1 << db_of(g)) - 32'd1);
                if (ml[g].size() != 0) void'(ml[g].pop_front());
                if (ml[g].size() == 0 && mq[g].size() != 0) add_frame(g, mq[g].pop_front());
                if (take) mq[g].push_back(w);
            end
        end
    end

    // ------------------------------------------------------------- checking
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_cnt [NI];

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < NI; g++) begin
            int etx;
            etx = (ml[g].size() != 0) ? int'(ml[g][0]) : 1;
            chk($sformatf("i%0d tx_out", g), int'(tx_v[g]), etx);
            chk($sformatf("i%0d busy", g), int'(busy_v[g]), (ml[g].size() != 0) ? 1 : 0);
            chk($sformatf("i%0d fifo_count", g), int'(cnt_v[g]), mq[g].size());
            chk($sformatf("i%0d in_ready", g), int'(rdy_v[g]), (mq[g].size() != fd_of(g)) ? 1 : 0);
            busy_cnt[g] += int'(busy_v[g]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic wait_to(int t);
        while (cyc < t) step();
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int n0;
        int acc;
        int low;
        logic [8:0] p0, p1, p2, p3;

        reset = 1'b1;
        vld_v = '0;
        for (int g = 0; g < NI; g++) dat_v[g] = '0;
        for (int g = 0; g < NI; g++) busy_cnt[g] = 0;
        repeat (3) step();
        chk("reset tx_out", int'(tx_v[0]), 1);
        chk("reset busy", int'(busy_v[0]), 0);
        chk("reset fifo_count", int'(cnt_v[4]), 0);
        chk("reset in_ready", int'(rdy_v[4]), 1);
        reset = 1'b0;
        repeat (4) step();

        // Single words on instances 0..3, six-cycle burst on instance 4.
        for (int g = 0; g < NI; g++) busy_cnt[g] = 0;
        n0  = cyc + 1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                vld_v[3:0] = 4'hF;
                dat_v[0] = 9'h055;
                dat_v[1] = 9'h007;
                dat_v[2] = 9'h007;
                dat_v[3] = 9'h1A5;
            end
            vld_v[4] = 1'b1;
            dat_v[4] = 9'(i + 1);
            if (i == 5) begin
                chk("full fifo_count", int'(cnt_v[4]), 4);
                chk("full in_ready", int'(rdy_v[4]), 0);
            end
            if (rdy_v[4]) acc++;
            step();
            if (i == 0) begin
                vld_v[3:0] = '0;
                chk("write+0 tx_out", int'(tx_v[0]), 1);
                chk("write+0 fifo_count", int'(cnt_v[0]), 1);
            end
            if (i == 1) begin
                chk("pop tx_out", int'(tx_v[0]), 0);
                chk("pop busy", int'(busy_v[0]), 1);
                chk("pop fifo_count", int'(cnt_v[0]), 0);
            end
        end
        vld_v[4] = 1'b0;
        chk("burst accepted", acc, 5);

        // Mid-bit samples of data (and parity / first stop) bits.
        p0 = 9'h155;  // 0x55 then stop
        p1 = 9'h107;  // 0x07 then even parity 1
        p2 = 9'h007;  // 0x07 then odd parity 0
        p3 = 9'h1A5;  // nine data bits
        for (int i = 0; i < 9; i++) begin
            wait_to(n0 + 25 + 16 * i);
            chk($sformatf("8N1 bit%0d", i), int'(tx_v[0]), int'(p0[i]));
            chk($sformatf("8E1 bit%0d", i), int'(tx_v[1]), int'(p1[i]));
            chk($sformatf("8O1 bit%0d", i), int'(tx_v[2]), int'(p2[i]));
            chk($sformatf("9N2 bit%0d", i), int'(tx_v[3]), int'(p3[i]));
        end
        wait_to(n0 + 160);
        chk("8N1 busy last", int'(busy_v[0]), 1);
        wait_to(n0 + 161);
        chk("8N1 busy end", int'(busy_v[0]), 0);
        chk("8N1 tx idle", int'(tx_v[0]), 1);
        wait_to(n0 + 169);
        chk("9N2 stop1", int'(tx_v[3]), 1);
        chk("8E1 stop", int'(tx_v[1]), 1);
        wait_to(n0 + 185);
        chk("9N2 stop2", int'(tx_v[3]), 1);
        wait_to(n0 + 900);
        chk("8N1 frame length", busy_cnt[0], 160);
        chk("8E1 frame length", busy_cnt[1], 176);
        chk("8O1 frame length", busy_cnt[2], 176);
        chk("9N2 frame length", busy_cnt[3], frame_len(3));
        chk("depth4 five frames", busy_cnt[4], 5 * 160);

        // Write landing on the final stop cycle while one word is queued.
        n0 = cyc + 1;
        vld_v[0] = 1'b1;
        dat_v[0] = 9'h0A3;
        step();
        dat_v[0] = 9'h03C;
        step();
        vld_v[0] = 1'b0;
        wait_to(n0 + 160);
        chk("wp fifo_count before", int'(cnt_v[0]), 1);
        vld_v[0] = 1'b1;
        dat_v[0] = 9'h096;
        step();
        vld_v[0] = 1'b0;
        chk("wp fifo_count", int'(cnt_v[0]), 1);
        chk("wp start no gap", int'(tx_v[0]), 0);
        chk("wp busy", int'(busy_v[0]), 1);
        wait_to(n0 + 161 + 2 * 160 + 10);

        // Reset during data bit 3 with three words queued.
        n0 = cyc + 1;
        vld_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat_v[0] = 9'($urandom);
            step();
        end
        vld_v[0] = 1'b0;
        wait_to(n0 + 70);
        chk("pre-reset fifo_count", int'(cnt_v[0]), 3);
        reset = 1'b1;
        #1;
        chk("async reset tx_out", int'(tx_v[0]), 1);
        chk("async reset busy", int'(busy_v[0]), 0);
        chk("async reset fifo_count", int'(cnt_v[0]), 0);
        chk("async reset in_ready", int'(rdy_v[0]), 1);
        compare_all();
        step();
        reset = 1'b0;
        low = 0;
        repeat (500) begin
            step();
            if (!tx_v[0] || busy_v[0]) low++;
        end
        chk("quiet after reset", low, 0);

        // Random traffic: sparse, then dense enough to fill every FIFO.
        for (int i = 0; i < 3000; i++) begin
            for (int g = 0; g < NI; g++) begin
                vld_v[g] = ($urandom_range(0, 99) < ((i < 1500) ? 3 : 25));
                dat_v[g] = 9'($urandom);
            end
            step();
        end
        vld_v = '0;
        repeat (3400) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
